// File: rtl/cd_rx_frame.sv
// cd_rx_frame: CDBUS frame assembler feeding cd_rx_ram (CRC16-Modbus check).
// Define CD_RX_FILTER_EN to build destination address filtering.
module cd_rx_frame #(
    parameter int MAX_DATA = 251
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] bus_byte,
    input  logic       bus_byte_en,
    input  logic       bus_idle,
    input  logic       bus_err,
    input  logic [7:0] filter,
    input  logic       promiscuous,
    input  logic       crc_err_pass,
    output logic [7:0] wr_byte,
    output logic [7:0] wr_addr,
    output logic       wr_en,
    output logic       wr_err,
    output logic       switch,
    output logic       crc_err,
    output logic       frame_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RECV = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;
    localparam logic [7:0] MAX_LEN = 8'(MAX_DATA);

    logic [1:0]  state, state_n;
    logic [8:0]  cnt, cnt_n, c0, last;
    logic [15:0] crc, crc_n, k0;
    logic [7:0]  len, len_n;
    logic [7:0]  wr_byte_n, wr_addr_n;
    logic        wr_en_n, wr_err_n, switch_n, crc_err_n, frame_err_n;
    logic        drop, reject;

    function automatic logic [15:0] crc16_byte(input logic [15:0] c_in,
                                               input logic [7:0]  d);
        logic [15:0] c;
        c = c_in ^ {8'h00, d};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        return c;
    endfunction

`ifdef CD_RX_FILTER_EN
    assign reject = !(bus_byte == filter || bus_byte == 8'hFF || promiscuous);
`else
    logic unused_filter;
    assign unused_filter = ^{filter, promiscuous};
    assign reject = 1'b0;
`endif

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        crc_n       = crc;
        len_n       = len;
        c0          = cnt;
        k0          = crc;
        last        = 9'd0;
        drop        = 1'b0;
        wr_byte_n   = wr_byte;
        wr_addr_n   = wr_addr;
        wr_en_n     = 1'b0;
        wr_err_n    = wr_err;
        switch_n    = 1'b0;
        crc_err_n   = 1'b0;
        frame_err_n = 1'b0;

        if (state == S_DROP) begin
            if (bus_idle)
                state_n = S_IDLE;
        end else if (state == S_RECV && bus_err) begin
            frame_err_n = 1'b1;
            state_n     = bus_idle ? S_IDLE : S_DROP;
        end else if (state == S_RECV || (bus_byte_en && !bus_err)) begin
            if (state == S_IDLE) begin
                c0 = 9'd0;
                k0 = 16'hFFFF;
            end
            state_n = S_RECV;
            cnt_n   = c0;
            crc_n   = k0;
            if (bus_byte_en) begin
                if (c0 == 9'd1 && reject) begin
                    drop = 1'b1;
                end else if (c0 == 9'd2 && bus_byte > MAX_LEN) begin
                    drop        = 1'b1;
                    frame_err_n = 1'b1;
                end
                if (drop) begin
                    state_n = bus_idle ? S_IDLE : S_DROP;
                end else begin
                    if (!c0[8]) begin
                        wr_en_n   = 1'b1;
                        wr_addr_n = c0[7:0];
                        wr_byte_n = bus_byte;
                    end
                    cnt_n = c0[8] ? c0 : c0 + 9'd1;
                    crc_n = crc16_byte(k0, bus_byte);
                    if (c0 == 9'd2)
                        len_n = bus_byte;
                end
            end
            // end check sees the byte taken in this same cycle
            if (bus_idle && !drop) begin
                state_n = S_IDLE;
                last    = cnt_n - 9'd1;
                if (cnt_n < 9'd5 || cnt_n != {1'b0, len_n} + 9'd5) begin
                    frame_err_n = 1'b1;
                end else if (crc_n == 16'h0000) begin
                    switch_n  = 1'b1;
                    wr_err_n  = 1'b0;
                    wr_addr_n = last[7:0];
                end else begin
                    crc_err_n = 1'b1;
                    if (crc_err_pass) begin
                        switch_n  = 1'b1;
                        wr_err_n  = 1'b1;
                        wr_addr_n = last[7:0];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= 9'd0;
            crc       <= 16'hFFFF;
            len       <= 8'd0;
            wr_byte   <= 8'd0;
            wr_addr   <= 8'd0;
            wr_en     <= 1'b0;
            wr_err    <= 1'b0;
            switch    <= 1'b0;
            crc_err   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            crc       <= crc_n;
            len       <= len_n;
            wr_byte   <= wr_byte_n;
            wr_addr   <= wr_addr_n;
            wr_en     <= wr_en_n;
            wr_err    <= wr_err_n;
            switch    <= switch_n;
            crc_err   <= crc_err_n;
            frame_err <= frame_err_n;
        end
    end

endmodule

// File: tb/tb_cd_rx_frame.sv
// tb_cd_rx_frame: randomized and directed frames against a frame-level model.
// Expectations follow CD_RX_FILTER_EN the same way the design build does.
module tb_cd_rx_frame;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] bus_byte = 8'd0;
    logic       bus_byte_en = 1'b0;
    logic       bus_idle = 1'b0;
    logic       bus_err = 1'b0;
    logic [7:0] filter = 8'h02;
    logic       promiscuous = 1'b0;
    logic       crc_err_pass = 1'b0;
    logic [7:0] wr_byte, wr_addr;
    logic       wr_en, wr_err, switch, crc_err, frame_err;

`ifdef CD_RX_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif
    localparam int MAXD = 251;

    cd_rx_frame dut (
        .clk(clk), .reset_n(reset_n),
        .bus_byte(bus_byte), .bus_byte_en(bus_byte_en),
        .bus_idle(bus_idle), .bus_err(bus_err),
        .filter(filter), .promiscuous(promiscuous),
        .crc_err_pass(crc_err_pass),
        .wr_byte(wr_byte), .wr_addr(wr_addr), .wr_en(wr_en),
        .wr_err(wr_err), .switch(switch),
        .crc_err(crc_err), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  frm[$];
    logic [15:0] obs_w[$];
    logic [15:0] exp_w[$];
    int          sw_n, crc_n, ferr_n, sw_cyc, idle_cyc, gap;
    logic [7:0]  sw_addr, sw_addr2;
    logic        sw_err;
    bit          prev_sw = 1'b0;
    int          e_sw, e_crc, e_ferr;
    logic [7:0]  e_addr;
    logic        e_werr;

    always @(negedge clk) begin
        if (wr_en) obs_w.push_back({wr_addr, wr_byte});
        if (prev_sw) sw_addr2 = wr_addr;
        prev_sw = switch;
        if (switch) begin
            sw_n++;
            sw_addr = wr_addr;
            sw_err  = wr_err;
            sw_cyc  = cyc;
        end
        if (crc_err) crc_n++;
        if (frame_err) ferr_n++;
    end

    function automatic logic [15:0] crc_of(input int n);
        logic [15:0] c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {8'h00, frm[i]};
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    function automatic bit writes_ok();
        if (obs_w.size() != exp_w.size()) return 1'b0;
        foreach (exp_w[i])
            if (obs_w[i] !== exp_w[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic add_crc();
        logic [15:0] c = crc_of(frm.size());
        frm.push_back(c[7:0]);
        frm.push_back(c[15:8]);
    endtask

    // mode: 0 good, 1 corrupt crc_h, 2 extra byte, 3 missing byte
    task automatic build(input logic [7:0] dst, input logic [7:0] len,
                         input int mode);
        frm.delete();
        frm.push_back(8'($urandom));
        frm.push_back(dst);
        frm.push_back(len);
        for (int i = 0; i < int'(len); i++) frm.push_back(8'($urandom));
        add_crc();
        if (mode == 1) frm[frm.size()-1] = frm[frm.size()-1] ^ 8'h40;
        if (mode == 2) frm.push_back(8'($urandom));
        if (mode == 3) void'(frm.pop_back());
    endtask

    // frame-level outcome: earliest of bus_err / dst reject / oversize len
    task automatic model(input int err_pos);
        int n = frm.size();
        int ev_rej, ev_len, ev_err, first, stop;
        logic [15:0] c;
        exp_w.delete();
        e_sw = 0; e_crc = 0; e_ferr = 0; e_addr = 8'd0; e_werr = 1'b0;
        ev_rej = (FILT && n > 1 && !(frm[1] == filter || frm[1] == 8'hFF
                  || promiscuous)) ? 1 : 1000;
        ev_len = (n > 2 && int'(frm[2]) > MAXD) ? 2 : 1000;
        ev_err = (err_pos >= 1) ? err_pos : 1000;
        first = ev_rej < ev_len ? ev_rej : ev_len;
        first = ev_err < first ? ev_err : first;
        if (first < 1000 && ev_err == first) begin
            stop = err_pos; e_ferr = 1;
        end else if (first < 1000 && ev_rej == first) begin
            stop = 1;
        end else if (first < 1000) begin
            stop = 2; e_ferr = 1;
        end else begin
            stop = n > 256 ? 256 : n;
            if (n < 5 || n != int'(frm[2]) + 5) begin
                e_ferr = 1;
            end else begin
                c = crc_of(n);
                if (c == 16'h0000) begin
                    e_sw = 1; e_addr = 8'(n - 1);
                end else begin
                    e_crc = 1;
                    if (crc_err_pass) begin
                        e_sw = 1; e_werr = 1'b1; e_addr = 8'(n - 1);
                    end
                end
            end
        end
        for (int i = 0; i < stop; i++) exp_w.push_back({8'(i), frm[i]});
    endtask

    task automatic run_frame(input int err_pos, input bit coinc);
        obs_w.delete();
        sw_n = 0; crc_n = 0; ferr_n = 0; sw_cyc = -1;
        sw_addr = 8'd0; sw_addr2 = 8'd0; sw_err = 1'b0; idle_cyc = 0;
        for (int i = 0; i < frm.size(); i++) begin
            @(posedge clk); #1;
            bus_byte_en = 1'b0; bus_err = 1'b0;
            if (i > 0)
                for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
            bus_byte = frm[i];
            bus_byte_en = 1'b1;
            bus_err = (i == err_pos);
            if (coinc && i == frm.size() - 1) begin
                bus_idle = 1'b1; idle_cyc = cyc;
            end
        end
        @(posedge clk); #1;
        bus_byte_en = 1'b0; bus_err = 1'b0;
        if (!coinc) begin
            bus_idle = 1'b1; idle_cyc = cyc;
            @(posedge clk); #1;
        end
        bus_idle = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        model(err_pos);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({wr_byte, wr_addr, wr_en, wr_err, switch, crc_err, frame_err} !== 21'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0",
                     {wr_byte, wr_addr, wr_en, wr_err, switch, crc_err, frame_err});
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_valid();
        filter = 8'h02; promiscuous = 1'b0; crc_err_pass = 1'b0; gap = 0;
        frm.delete();
        frm.push_back(8'h01); frm.push_back(8'h02);
        frm.push_back(8'h01); frm.push_back(8'hAA);
        add_crc();
        run_frame(-1, 1'b0);
        checks++;
        if (!writes_ok() || obs_w.size() != 6) begin
            errors++;
            $display("FAIL valid_writes got %0d writes want 6", obs_w.size());
        end
        checks++;
        if (sw_n !== 1 || sw_cyc !== idle_cyc + 1) begin
            errors++;
            $display("FAIL valid_switch got n=%0d cyc=%0d want n=1 cyc=%0d",
                     sw_n, sw_cyc, idle_cyc + 1);
        end
        checks++;
        if (sw_addr !== 8'd5 || sw_addr2 !== 8'd5 || sw_err !== 1'b0) begin
            errors++;
            $display("FAIL valid_commit got addr=%0d/%0d err=%0b want 5/5 err=0",
                     sw_addr, sw_addr2, sw_err);
        end
    endtask

    task automatic test_crc_fail();
        for (int p = 0; p < 2; p++) begin
            crc_err_pass = p[0];
            frm.delete();
            frm.push_back(8'h01); frm.push_back(8'h02);
            frm.push_back(8'h01); frm.push_back(8'hAA);
            add_crc();
            frm[5] = frm[5] ^ 8'h01;
            run_frame(-1, 1'b0);
            checks++;
            if (crc_n !== 1 || sw_n !== p || ferr_n !== 0) begin
                errors++;
                $display("FAIL crc_fail_pass%0d got crc=%0d sw=%0d ferr=%0d want 1 %0d 0",
                         p, crc_n, sw_n, ferr_n, p);
            end
            if (p == 1) begin
                checks++;
                if (sw_err !== 1'b1 || sw_addr !== 8'd5) begin
                    errors++;
                    $display("FAIL crc_pass_commit got err=%0b addr=%0d want 1 5",
                             sw_err, sw_addr);
                end
            end
        end
        crc_err_pass = 1'b0;
    endtask

    task automatic test_filter();
        filter = 8'h02; promiscuous = 1'b0;
        build(8'h05, 8'd2, 0);
        run_frame(-1, 1'b0);
        checks++;
        if (!writes_ok() || sw_n !== e_sw || crc_n !== 0 || ferr_n !== 0) begin
            errors++;
            $display("FAIL filter_reject got w=%0d sw=%0d crc=%0d ferr=%0d want w=%0d sw=%0d 0 0",
                     obs_w.size(), sw_n, crc_n, ferr_n, exp_w.size(), e_sw);
        end
        build(8'hFF, 8'd3, 0);
        run_frame(-1, 1'b0);
        checks++;
        if (sw_n !== 1 || !writes_ok()) begin
            errors++;
            $display("FAIL filter_bcast got sw=%0d w=%0d want 1 %0d",
                     sw_n, obs_w.size(), exp_w.size());
        end
    endtask

    task automatic test_len();
        build(8'h02, 8'hFC, 0);
        run_frame(-1, 1'b0);
        checks++;
        if (ferr_n !== 1 || sw_n !== 0 || obs_w.size() > 2 || !writes_ok()) begin
            errors++;
            $display("FAIL len_oversize got ferr=%0d sw=%0d w=%0d want 1 0 %0d",
                     ferr_n, sw_n, obs_w.size(), exp_w.size());
        end
        build(8'h02, 8'd3, 0);
        void'(frm.pop_back());
        void'(frm.pop_back());
        run_frame(-1, 1'b0);
        checks++;
        if (ferr_n !== 1 || sw_n !== 0 || obs_w.size() != 6) begin
            errors++;
            $display("FAIL len_short got ferr=%0d sw=%0d w=%0d want 1 0 6",
                     ferr_n, sw_n, obs_w.size());
        end
    endtask

    task automatic test_bus_err();
        build(8'h02, 8'd4, 0);
        run_frame(3, 1'b0);
        checks++;
        if (ferr_n !== 1 || sw_n !== 0 || obs_w.size() != 3) begin
            errors++;
            $display("FAIL bus_err got ferr=%0d sw=%0d w=%0d want 1 0 3",
                     ferr_n, sw_n, obs_w.size());
        end
        build(8'h02, 8'd2, 0);
        run_frame(-1, 1'b0);
        checks++;
        if (sw_n !== 1 || obs_w.size() == 0 || obs_w[0][15:8] !== 8'd0
            || !writes_ok()) begin
            errors++;
            $display("FAIL after_err got sw=%0d w=%0d want sw=1 w=%0d from addr 0",
                     sw_n, obs_w.size(), exp_w.size());
        end
    endtask

    task automatic test_back_to_back();
        build(8'h02, 8'd5, 0);
        run_frame(-1, 1'b1);
        checks++;
        if (sw_n !== 1 || sw_cyc !== idle_cyc + 1 || sw_addr !== 8'd9
            || !writes_ok()) begin
            errors++;
            $display("FAIL coincident got sw=%0d cyc=%0d addr=%0d want 1 %0d 9",
                     sw_n, sw_cyc, sw_addr, idle_cyc + 1);
        end
    endtask

    task automatic test_max_frame();
        build(8'h02, 8'd251, 0);
        run_frame(-1, 1'b0);
        checks++;
        if (sw_n !== 1 || sw_addr !== 8'd255 || obs_w.size() != 256
            || !writes_ok()) begin
            errors++;
            $display("FAIL max_frame got sw=%0d addr=%0d w=%0d want 1 255 256",
                     sw_n, sw_addr, obs_w.size());
        end
    endtask

    task automatic test_reset_mid();
        sw_n = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bus_byte = 8'(i + 1); bus_byte_en = 1'b1;
        end
        @(posedge clk); #1;
        bus_byte_en = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({wr_byte, wr_addr, wr_en, wr_err, switch, crc_err, frame_err} !== 21'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs got %h want 0",
                     {wr_byte, wr_addr, wr_en, wr_err, switch, crc_err, frame_err});
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        bus_idle = 1'b1;
        @(posedge clk); #1;
        bus_idle = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sw_n !== 0) begin
            errors++;
            $display("FAIL reset_mid_switch got %0d want 0", sw_n);
        end
    endtask

    task automatic test_random();
        logic [7:0] dst, len;
        int mode, ep, sel;
        bit coinc;
        for (int t = 0; t < 60; t++) begin
            filter       = 8'($urandom_range(0, 254));
            promiscuous  = ($urandom_range(0, 3) == 0);
            crc_err_pass = $urandom_range(0, 1);
            gap          = $urandom_range(0, 2);
            sel = $urandom_range(0, 2);
            dst = (sel == 0) ? filter : (sel == 1) ? 8'hFF : 8'($urandom);
            len = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(252, 255))
                                              : 8'($urandom_range(0, 12));
            mode = $urandom_range(0, 5);
            if (mode > 3) mode = 0;
            build(dst, len, mode);
            ep = ($urandom_range(0, 5) == 0)
                 ? $urandom_range(1, frm.size() - 1) : -1;
            coinc = $urandom_range(0, 1);
            run_frame(ep, coinc);
            checks++;
            if (!writes_ok() || sw_n !== e_sw || crc_n !== e_crc
                || ferr_n !== e_ferr) begin
                errors++;
                $display("FAIL rand%0d got w=%0d sw=%0d crc=%0d ferr=%0d want w=%0d sw=%0d crc=%0d ferr=%0d",
                         t, obs_w.size(), sw_n, crc_n, ferr_n,
                         exp_w.size(), e_sw, e_crc, e_ferr);
            end
            if (e_sw == 1) begin
                checks++;
                if (sw_addr !== e_addr || sw_err !== e_werr
                    || sw_cyc !== idle_cyc + 1) begin
                    errors++;
                    $display("FAIL rand%0d_commit got addr=%0d err=%0b cyc=%0d want %0d %0b %0d",
                             t, sw_addr, sw_err, sw_cyc, e_addr, e_werr,
                             idle_cyc + 1);
                end
            end
        end
    endtask

    initial begin
        gap = 0;
        test_reset();
        test_valid();
        test_crc_fail();
        test_filter();
        test_len();
        test_bus_err();
        test_back_to_back();
        test_max_frame();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
